// File: rtl/compare_sweep.sv
// =============================================================================
// Module      : compare_sweep
// Description : Sweeps a 4-bit comparison unit through equal/greater/less/max
//               for one latched operand pair and checks each result against
//               an internal reference.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module compare_sweep #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] X_in,
    input  logic [3:0] Y_in,
    input  logic [3:0] f,
    output logic [3:0] X,
    output logic [3:0] Y,
    output logic [1:0] select,
    output logic       busy,
    output logic       done,
    output logic       eq,
    output logic       gt,
    output logic       lt,
    output logic [3:0] max,
    output logic [3:0] mismatch
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] C_RELOAD = 4'(SETTLE - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_cap_eq;
    logic       r_cap_gt;
    logic       r_cap_lt;
    logic [2:0] r_mis;

    logic [3:0] w_expect;
    logic       w_miss;

    always_comb begin
        w_expect = 4'd0;
        unique case (select)
            2'd0:    w_expect = {3'b000, X == Y};
            2'd1:    w_expect = {3'b000, X > Y};
            2'd2:    w_expect = {3'b000, X < Y};
            default: w_expect = (X < Y) ? Y : X;
        endcase
    end

    assign w_miss = (f != w_expect);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_cap_eq <= 1'b0;
            r_cap_gt <= 1'b0;
            r_cap_lt <= 1'b0;
            r_mis    <= 3'd0;
            X        <= 4'd0;
            Y        <= 4'd0;
            select   <= 2'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            eq       <= 1'b0;
            gt       <= 1'b0;
            lt       <= 1'b0;
            max      <= 4'd0;
            mismatch <= 4'd0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        X       <= X_in;
                        Y       <= Y_in;
                        select  <= 2'd0;
                        r_cnt   <= C_RELOAD;
                        busy    <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    if (select == 2'd3) begin
                        // Publish on entry to DONE so done is high for the whole DONE cycle;
                        // the max sample bypasses its capture slot.
                        eq       <= r_cap_eq;
                        gt       <= r_cap_gt;
                        lt       <= r_cap_lt;
                        max      <= f;
                        mismatch <= {w_miss, r_mis};
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        r_state  <= S_DONE;
                    end else begin
                        unique case (select)
                            2'd0: begin
                                r_cap_eq <= f[0];
                                r_mis[0] <= w_miss;
                            end
                            2'd1: begin
                                r_cap_gt <= f[0];
                                r_mis[1] <= w_miss;
                            end
                            default: begin
                                r_cap_lt <= f[0];
                                r_mis[2] <= w_miss;
                            end
                        endcase
                        select  <= select + 2'd1;
                        r_cnt   <= C_RELOAD;
                        r_state <= S_WAIT;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/compare_sweep.md
# compare_sweep

Sequential driver and checker for the 4-bit comparison unit. On `start` it latches an operand pair, presents it on `X`/`Y`, and steps `select` through all four functions (equal, greater, less, max). After a programmable settle time per step it samples the unit's `f` output. It then publishes the four results together with a per-function mismatch mask computed against an internal reference. It sits on the initiator side of the comparator, between a host or button front end and the `Comparison` block.

## Interface
- `SETTLE`, default 1: cycles `f` is allowed to settle after `select`/`X`/`Y` change, before sampling. Legal range 1..15.
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `start` input 1: request a sweep; sampled only in IDLE.
- `X_in` input 4: operand X, latched on the accepting edge.
- `Y_in` input 4: operand Y, latched on the accepting edge.
- `f` input 4: result from the comparison unit.
- `X` output 4: operand X driven to the comparator; holds the latched value.
- `Y` output 4: operand Y driven to the comparator.
- `select` output 2: function select. 0 = equal, 1 = greater, 2 = less, 3 = max.
- `busy` output 1: high from the accepting edge until `done` is asserted.
- `done` output 1: one-cycle pulse; the result outputs are valid from this cycle on.
- `eq`, `gt`, `lt` output 1 each: `f[0]` as sampled at select 0, 1 and 2.
- `max` output 4: `f` as sampled at select 3.
- `mismatch` output 4: bit k set if the sample at select k differed from the expected value.

## Operation
- States: IDLE, WAIT, SAMPLE, DONE. The reset state is IDLE.
- Reset values are all zero: `X`, `Y`, `select`, `busy`, `done`, `eq`, `gt`, `lt`, `max`, `mismatch`, the settle counter, and the capture registers.
- IDLE, `start` = 1:
  - latch `X` <= `X_in` and `Y` <= `Y_in`;
  - set `select` <= 0 and counter <= `SETTLE` - 1;
  - set `busy` <= 1 and go to WAIT.
- IDLE, `start` = 0: hold state. `start` outside IDLE is ignored; there is no queuing.
- WAIT: if counter = 0, go to SAMPLE; else decrement the counter.
- SAMPLE:
  - capture `f` into slot `select`;
  - compare it with the expected value and record the result in the mismatch bit for `select`.
  - If `select` = 3, go to DONE. Otherwise `select` <= `select` + 1, reload the counter with `SETTLE` - 1, and return to WAIT.
- DONE:
  - copy the capture registers to `eq`, `gt`, `lt`, `max` and `mismatch`;
  - assert `done` and drop `busy`;
  - go to IDLE.
- Expected values are computed from the latched `X` and `Y` as unsigned 4-bit values:
  - select 0 expects {3'b000, X==Y};
  - select 1 expects {3'b000, X>Y};
  - select 2 expects {3'b000, X<Y};
  - select 3 expects (X<Y ? Y : X).
  - All 4 bits of `f` are compared; upper bits must be zero for select 0..2.
- `X`, `Y` and `select` stay at their last values after DONE until the next accepted `start`.
- Published results hold until the next DONE. They are not cleared at `start`.
- An asynchronous `reset` mid-sweep:
  - forces IDLE and zeros every output immediately;
  - discards any partial captures;
  - leaves no pending `done`.

## Timing
- Each select step takes `SETTLE` + 1 cycles: `SETTLE` in WAIT plus 1 in SAMPLE.
- Taking the accepting edge as edge 0, `done` is high in the cycle following edge 4*(`SETTLE`+1). With `SETTLE` = 1 that is edge 8.
- A `start` held high during DONE is not accepted. The earliest next accept is the first edge in IDLE, so back-to-back sweeps have one idle cycle between them.
- `select` changes only on the edge leaving SAMPLE. `f` is sampled on the edge leaving SAMPLE, after at least `SETTLE` + 1 full cycles of stable inputs.
- `done` lasts exactly one cycle. `busy` and `done` are never high together.

## Test plan
- Reset, then `X_in`=5, `Y_in`=5, pulse `start` with `SETTLE`=1 and an ideal comparator model on `f`:
  - `done` one cycle after edge 8;
  - `eq`=1, `gt`=0, `lt`=0, `max`=5, `mismatch`=0000.
- `X_in`=9, `Y_in`=3 gives `gt`=1, `max`=9. `X_in`=2, `Y_in`=14 gives `lt`=1, `max`=14. Both with `mismatch`=0.
- Fault injection with `X`=3, `Y`=7: the model forces `f`=4'b0010 at select 2 and `f`=3 at select 3. Expect `mismatch`=1100 and `lt`=0.
- `SETTLE`=4, `X_in`=15, `Y_in`=0: `select` holds each value for 5 cycles, and `done` comes one cycle after edge 20.
- `start` pulsed at edge 3 of a sweep:
  - the pulse is ignored;
  - `X_in` changed mid-sweep does not alter `X`;
  - exactly one `done` pulse occurs.
- Assert `reset` asynchronously at edge 5 of a sweep:
  - all outputs are 0 before the next edge;
  - no `done` pulse;
  - a new `start` after release completes normally.
